// File: rtl/mixer_ctrl_pkg.sv
// Shared definitions for the mixer controller: FSM encoding and default widths.
package mixer_ctrl_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int PHASE_W_DEF = 16;
  localparam int LUT_AW      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mixer_ctrl_nco_phase_acc.sv
// NCO phase accumulator; exposes only the top OUT_W bits used to address the sin/cos LUT.
module nco_phase_acc #(
  parameter int W     = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     inc,
  output logic [OUT_W-1:0] phase
);

  logic [W-1:0] acc;

  // Wraps naturally modulo 2^W; clear wins over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + inc;
    end
  end

  assign phase = acc[W-1 -: OUT_W];

endmodule

// File: rtl/mixer_ctrl.sv
// Mixer job controller: streams samples past an NCO-addressed sin/cos LUT into an
// external complex multiplier and writes each product back to a result RAM.
module mixer_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [ADDR_W-1:0]  len_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               smp_rd_o,
  output logic [ADDR_W-1:0]  smp_addr_o,
  input  logic [7:0]         smp_real_i,
  input  logic [7:0]         smp_imag_i,
  output logic [LUT_AW-1:0]  lut_addr_o,
  input  logic [7:0]         lut_cos_i,
  input  logic [7:0]         lut_sin_i,
  output logic [7:0]         mult_real_o,
  output logic [7:0]         mult_imag_o,
  output logic [7:0]         mult_cos_o,
  output logic [7:0]         mult_sin_o,
  output logic               mult_valid_o,
  input  logic [15:0]        mult_yreal_i,
  input  logic [15:0]        mult_yimag_i,
  input  logic               mult_valid_i,
  output logic               res_we_o,
  output logic [ADDR_W-1:0]  res_addr_o,
  output logic [31:0]        res_data_o
);

  state_t             state;
  logic [ADDR_W-1:0]  len_q;
  logic [ADDR_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0]  wr_cnt;
  logic [PHASE_W-1:0] inc_q;
  logic               abort_hit;
  logic               acc_clr;

  assign abort_hit  = abort_i && ((state == S_RUN) || (state == S_DRAIN));
  assign acc_clr    = (state == S_IDLE) && start_i;
  assign smp_addr_o = rd_cnt;

  // Operands are gated by the strobe so they read as zero outside a valid beat.
  assign mult_real_o = mult_valid_o ? smp_real_i : 8'd0;
  assign mult_imag_o = mult_valid_o ? smp_imag_i : 8'd0;
  assign mult_cos_o  = mult_valid_o ? lut_cos_i  : 8'd0;
  assign mult_sin_o  = mult_valid_o ? lut_sin_i  : 8'd0;

  nco_phase_acc #(
    .W     (PHASE_W),
    .OUT_W (LUT_AW)
  ) u_nco (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (smp_rd_o),
    .inc   (inc_q),
    .phase (lut_addr_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= '0;
      inc_q        <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      smp_rd_o     <= 1'b0;
      mult_valid_o <= 1'b0;
      res_we_o     <= 1'b0;
      res_addr_o   <= '0;
      res_data_o   <= '0;
    end else begin
      done_o       <= 1'b0;
      res_we_o     <= 1'b0;
      mult_valid_o <= smp_rd_o && !abort_hit;

      if (abort_hit) begin
        // Abort drops everything in flight; late results land in IDLE and are ignored.
        state    <= S_IDLE;
        busy_o   <= 1'b0;
        smp_rd_o <= 1'b0;
      end else begin
        if (mult_valid_i && (state != S_IDLE)) begin
          res_we_o   <= 1'b1;
          res_addr_o <= wr_cnt;
          res_data_o <= {mult_yreal_i, mult_yimag_i};
          wr_cnt     <= wr_cnt + ADDR_W'(1);
        end

        case (state)
          S_IDLE: begin
            if (start_i) begin
              len_q  <= len_i;
              inc_q  <= phase_inc_i;
              rd_cnt <= '0;
              wr_cnt <= '0;
              busy_o <= 1'b1;
              if (len_i == '0) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end else begin
                state    <= S_RUN;
                smp_rd_o <= 1'b1;
              end
            end
          end

          S_RUN: begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
            if (rd_cnt == len_q - ADDR_W'(1)) begin
              state    <= S_DRAIN;
              smp_rd_o <= 1'b0;
            end
          end

          // Completion is keyed on the last write, so any multiplier latency works.
          S_DRAIN: begin
            if (res_we_o && (res_addr_o == len_q - ADDR_W'(1))) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end

          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mixer_ctrl.sv
// Directed bench for mixer_ctrl with behavioural sample RAM, sin/cos LUT,
// variable-latency complex multiplier and a result-write monitor.
module tb_mixer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [7:0]  len_i;
  logic [15:0] phase_inc_i;
  logic        busy_o, done_o, smp_rd_o;
  logic [7:0]  smp_addr_o;
  logic [7:0]  smp_real_i, smp_imag_i;
  logic [7:0]  lut_addr_o;
  logic [7:0]  lut_cos_i, lut_sin_i;
  logic [7:0]  mult_real_o, mult_imag_o, mult_cos_o, mult_sin_o;
  logic        mult_valid_o;
  logic [15:0] mult_yreal_i, mult_yimag_i;
  logic        mult_valid_i = 1'b0;
  logic        res_we_o;
  logic [7:0]  res_addr_o;
  logic [31:0] res_data_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;

  logic signed [7:0] mem_re [256];
  logic signed [7:0] mem_im [256];

  int          rd_addr_q [$];
  int          rd_lut_q  [$];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          done_cyc_q[$];
  logic        done_busy_q[$];

  logic [2:0]  pv = 3'b000;
  logic [31:0] py [3];

  mixer_ctrl #(.ADDR_W(8), .PHASE_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .len_i(len_i),
    .phase_inc_i(phase_inc_i), .busy_o(busy_o), .done_o(done_o), .smp_rd_o(smp_rd_o),
    .smp_addr_o(smp_addr_o), .smp_real_i(smp_real_i), .smp_imag_i(smp_imag_i),
    .lut_addr_o(lut_addr_o), .lut_cos_i(lut_cos_i), .lut_sin_i(lut_sin_i),
    .mult_real_o(mult_real_o), .mult_imag_o(mult_imag_o), .mult_cos_o(mult_cos_o),
    .mult_sin_o(mult_sin_o), .mult_valid_o(mult_valid_o), .mult_yreal_i(mult_yreal_i),
    .mult_yimag_i(mult_yimag_i), .mult_valid_i(mult_valid_i), .res_we_o(res_we_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cos_of(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sin_of(input logic [7:0] a);
    return a + 8'h11;
  endfunction

  function automatic logic [31:0] cmul(input logic signed [7:0] re, input logic signed [7:0] im,
                                       input logic signed [7:0] c, input logic signed [7:0] s);
    logic signed [15:0] yr, yi;
    yr = re * c - im * s;
    yi = re * s + im * c;
    return {yr, yi};
  endfunction

  function automatic logic [31:0] exp_data(input int idx, input int lut);
    return cmul(mem_re[idx], mem_im[idx], cos_of(8'(lut)), sin_of(8'(lut)));
  endfunction

  // External RAM/LUT models: one-cycle read latency.
  always @(posedge clk) begin
    if (smp_rd_o) begin
      smp_real_i <= mem_re[smp_addr_o];
      smp_imag_i <= mem_im[smp_addr_o];
    end
    lut_cos_i <= cos_of(lut_addr_o);
    lut_sin_i <= sin_of(lut_addr_o);
  end

  // Multiplier model with latency lat (1..4 cycles).
  always @(posedge clk) begin
    pv[0] <= mult_valid_o;
    py[0] <= cmul(mult_real_o, mult_imag_o, mult_cos_o, mult_sin_o);
    pv[1] <= pv[0];  py[1] <= py[0];
    pv[2] <= pv[1];  py[2] <= py[1];
    if (lat == 1) begin
      mult_valid_i <= mult_valid_o;
      {mult_yreal_i, mult_yimag_i} <= cmul(mult_real_o, mult_imag_o, mult_cos_o, mult_sin_o);
    end else begin
      mult_valid_i <= pv[lat-2];
      {mult_yreal_i, mult_yimag_i} <= py[lat-2];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (smp_rd_o) begin
        rd_addr_q.push_back(int'(smp_addr_o));
        rd_lut_q.push_back(int'(lut_addr_o));
      end
      if (res_we_o) begin
        wr_addr_q.push_back(int'(res_addr_o));
        wr_data_q.push_back(res_data_o);
        wr_cyc_q.push_back(cyc);
      end
      if (done_o) begin
        done_cyc_q.push_back(cyc);
        done_busy_q.push_back(busy_o);
      end
    end
  end

  task automatic clear_logs();
    rd_addr_q.delete(); rd_lut_q.delete(); wr_addr_q.delete();
    wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete(); done_busy_q.delete();
  endtask

  // Called at a negedge; returns the cycle in which start_i was high.
  task automatic do_start(input logic [7:0] len, input logic [15:0] inc, output int s);
    len_i = len; phase_inc_i = inc; start_i = 1'b1; s = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 0; abort_i = 0; len_i = 0; phase_inc_i = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, smp_rd_o, res_we_o, mult_valid_o} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                         {busy_o, done_o, smp_rd_o, res_we_o, mult_valid_o});
    end
    checks++;
    if ({lut_addr_o, smp_addr_o, res_addr_o, res_data_o} !== 56'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0",
                         {lut_addr_o, smp_addr_o, res_addr_o, res_data_o});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int s;
    int exp_lut[4] = '{'h00, 'h40, 'h80, 'hC0};
    lat = 2; clear_logs();
    for (int i = 0; i < 4; i++) begin mem_re[i] = 8'(i + 1); mem_im[i] = 8'sd0; end
    do_start(8'd4, 16'h4000, s);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %b expected 1", busy_o); end
    repeat (14) @(negedge clk);
    checks++;
    if (rd_lut_q.size() != 4) begin errors++; $display("[TB] FAIL basic_nreads: got %0d expected 4", rd_lut_q.size()); end
    for (int i = 0; i < 4 && i < rd_lut_q.size(); i++) begin
      checks++;
      if (rd_lut_q[i] != exp_lut[i] || rd_addr_q[i] != i) begin
        errors++; $display("[TB] FAIL basic_read%0d: got addr %0d lut %h expected addr %0d lut %h",
                           i, rd_addr_q[i], rd_lut_q[i], i, exp_lut[i]);
      end
    end
    checks++;
    if (wr_addr_q.size() != 4) begin errors++; $display("[TB] FAIL basic_nwrites: got %0d expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp_data(i, exp_lut[i])) begin
        errors++; $display("[TB] FAIL basic_write%0d: got addr %0d data %h expected addr %0d data %h",
                           i, wr_addr_q[i], wr_data_q[i], i, exp_data(i, exp_lut[i]));
      end
    end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++; $display("[TB] FAIL basic_ndone: got %0d expected 1", done_cyc_q.size());
    end else begin
      checks++;
      if (done_cyc_q[0] != s + 9) begin
        errors++; $display("[TB] FAIL basic_done_time: got %0d expected %0d", done_cyc_q[0] - s, 9);
      end
      checks++;
      if (wr_cyc_q.size() == 4 && done_cyc_q[0] != wr_cyc_q[3] + 1) begin
        errors++; $display("[TB] FAIL basic_done_after_write: got %0d expected %0d", done_cyc_q[0], wr_cyc_q[3] + 1);
      end
      checks++;
      if (done_busy_q[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_done: got %b expected 1", done_busy_q[0]); end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy_o); end
  endtask

  task automatic test_len_zero();
    int s;
    clear_logs();
    do_start(8'd0, 16'h1234, s);
    checks++;
    if ({done_o, busy_o} !== 2'b11) begin
      errors++; $display("[TB] FAIL zero_done_pulse: got done/busy %b expected 11", {done_o, busy_o});
    end
    repeat (6) @(negedge clk);
    checks++;
    if (rd_lut_q.size() != 0 || wr_addr_q.size() != 0 || done_cyc_q.size() != 1 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_traffic: got reads %0d writes %0d dones %0d busy %b expected 0 0 1 0",
                         rd_lut_q.size(), wr_addr_q.size(), done_cyc_q.size(), busy_o);
    end
  endtask

  task automatic test_wrap();
    int s;
    int exp_lut[3] = '{'h00, 'h80, 'h00};
    lat = 2; clear_logs();
    do_start(8'd3, 16'h8000, s);
    repeat (12) @(negedge clk);
    checks++;
    if (rd_lut_q.size() != 3) begin errors++; $display("[TB] FAIL wrap_nreads: got %0d expected 3", rd_lut_q.size()); end
    for (int i = 0; i < 3 && i < rd_lut_q.size(); i++) begin
      checks++;
      if (rd_lut_q[i] != exp_lut[i]) begin
        errors++; $display("[TB] FAIL wrap_lut%0d: got %h expected %h", i, rd_lut_q[i], exp_lut[i]);
      end
    end
    checks++;
    if (wr_addr_q.size() != 3 || done_cyc_q.size() != 1 || done_cyc_q[0] != s + 8) begin
      errors++; $display("[TB] FAIL wrap_complete: got writes %0d dones %0d expected 3 1 at cycle +8",
                         wr_addr_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_latency1();
    int s;
    int re[5] = '{3, -2, 5, 7, -8};
    int im[5] = '{1, 4, -3, 0, 2};
    lat = 1; clear_logs();
    for (int i = 0; i < 5; i++) begin mem_re[i] = 8'(re[i]); mem_im[i] = 8'(im[i]); end
    do_start(8'd5, 16'h0100, s);
    repeat (12) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 5) begin errors++; $display("[TB] FAIL lat1_nwrites: got %0d expected 5", wr_addr_q.size()); end
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp_data(i, i)) begin
        errors++; $display("[TB] FAIL lat1_write%0d: got addr %0d data %h expected addr %0d data %h",
                           i, wr_addr_q[i], wr_data_q[i], i, exp_data(i, i));
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 9) begin
      errors++; $display("[TB] FAIL lat1_done: got %0d pulses expected 1 at cycle +9", done_cyc_q.size());
    end
    lat = 2;
  endtask

  task automatic test_back_to_back();
    int s;
    int exp_lut[4] = '{'h00, 'h10, 'h20, 'h30};
    lat = 2; clear_logs();
    do_start(8'd4, 16'h1000, s);
    len_i = 8'd7; phase_inc_i = 16'h2000; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (rd_lut_q.size() != 4 || wr_addr_q.size() != 4) begin
      errors++; $display("[TB] FAIL b2b_counts: got reads %0d writes %0d expected 4 4", rd_lut_q.size(), wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < rd_lut_q.size(); i++) begin
      checks++;
      if (rd_lut_q[i] != exp_lut[i]) begin
        errors++; $display("[TB] FAIL b2b_lut%0d: got %h expected %h", i, rd_lut_q[i], exp_lut[i]);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 9) begin
      errors++; $display("[TB] FAIL b2b_done: got %0d pulses expected 1 at cycle +9", done_cyc_q.size());
    end
  endtask

  task automatic test_abort();
    int s;
    lat = 2; clear_logs();
    do_start(8'd8, 16'h0400, s);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (smp_rd_o !== 1'b1 || smp_addr_o !== 8'd2) begin
      errors++; $display("[TB] FAIL abort_third_read: got rd %b addr %0d expected 1 2", smp_rd_o, smp_addr_o);
    end
    abort_i = 1'b1; start_i = 1'b1; len_i = 8'd3;
    @(negedge clk);
    abort_i = 1'b0; start_i = 1'b0;
    checks++;
    if ({busy_o, smp_rd_o, done_o} !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_idle: got busy/rd/done %b expected 000", {busy_o, smp_rd_o, done_o});
    end
    repeat (12) @(negedge clk);
    checks++;
    if (rd_lut_q.size() != 3 || wr_addr_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++; $display("[TB] FAIL abort_quiet: got reads %0d writes %0d dones %0d expected 3 0 0",
                         rd_lut_q.size(), wr_addr_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    int s;
    lat = 2; clear_logs();
    for (int i = 0; i < 6; i++) begin mem_re[i] = 8'(10 + i); mem_im[i] = 8'(-3 - i); end
    do_start(8'd6, 16'h0800, s);
    repeat (7) @(negedge clk);
    checks++;
    if ({busy_o, smp_rd_o, res_we_o} !== 3'b101) begin
      errors++; $display("[TB] FAIL drain_state: got busy/rd/we %b expected 101", {busy_o, smp_rd_o, res_we_o});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, smp_rd_o, res_we_o, mult_valid_o, res_addr_o, res_data_o, lut_addr_o,
         smp_addr_o, mult_real_o, mult_imag_o, mult_cos_o, mult_sin_o} !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got we %b addr %0d data %h lut %h smp %0d re %h expected all 0",
                         res_we_o, res_addr_o, res_data_o, lut_addr_o, smp_addr_o, mult_real_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    clear_logs();
    do_start(8'd2, 16'h0800, s);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_addr_q[1] != 1 ||
        wr_data_q[0] !== exp_data(0, 'h00) || wr_data_q[1] !== exp_data(1, 'h08)) begin
      errors++; $display("[TB] FAIL post_reset_writes: got %0d writes expected 2 at addr 0,1 with data %h %h",
                         wr_addr_q.size(), exp_data(0, 'h00), exp_data(1, 'h08));
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 7) begin
      errors++; $display("[TB] FAIL post_reset_done: got %0d pulses expected 1 at cycle +7", done_cyc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_latency1();
    test_back_to_back();
    test_abort();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
